seq_divider: RTL



---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_ctrl.sv | 49 ++++
 rtl/seq_divider.sv | 77 +++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for seq_divider.
package div_pkg;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] ITER = 2'b10;
    localparam logic [1:0] DONE = 2'b11;
    localparam int DEFAULT_WIDTH = 4;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: FSM and step counter sequencing the divider datapath.
module seq_divider_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit ZERO_EXIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic zero,
    output logic busy,
    output logic done,
    output logic accept,
    output logic load,
    output logic step,
    output logic finish
);
    localparam int CW = clog2(WIDTH);
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= load ? CW'(WIDTH - 1) : step ? cnt - CW'(1) : cnt;
        end
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = (ZERO_EXIT && zero) ? DONE : ITER;
            ITER:    state_nxt = (cnt == '0) ? DONE : ITER;
            default: state_nxt = IDLE;
        endcase
    end
    // finish marks the edge entering DONE, where results are captured
    always_comb begin
        busy   = (state == LOAD) || (state == ITER);
        done   = state == DONE;
        accept = (state == IDLE) && start;
        load   = state == LOAD;
        step   = state == ITER;
        finish = state_nxt == DONE;
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider with start/done handshake.
// Define SEQ_DIV_ZERO_CHECK_EN for an early zero-divisor exit and div_by_zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam bit ZERO_EXIT = 1'b1;
`else
    localparam bit ZERO_EXIT = 1'b0;
`endif
    logic             accept, load, step, finish;
    logic [WIDTH-1:0] r, q, d, q_nxt, r_nxt;
    logic [WIDTH:0]   sh, trial;
    seq_divider_ctrl #(.WIDTH(WIDTH), .ZERO_EXIT(ZERO_EXIT)) u_ctrl (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .zero   (d == '0),
        .busy   (busy),
        .done   (done),
        .accept (accept),
        .load   (load),
        .step   (step),
        .finish (finish)
    );
    // R < D always holds between steps, so only the shifted value needs the extra bit
    assign sh    = {r, q[WIDTH-1]};
    assign trial = sh - {1'b0, d};
    assign r_nxt = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], ~trial[WIDTH]};
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                q <= dividend;
                d <= divisor;
            end
            if (load) r <= '0;
            if (step) begin
                r <= r_nxt;
                q <= q_nxt;
            end
            if (finish) begin
                quotient  <= step ? q_nxt : '1;
                remainder <= step ? r_nxt : q;
            end
        end
    end
`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic dz;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) dz <= 1'b0;
        else if (finish) dz <= !step;
    end
    assign div_by_zero = dz;
`else
    assign div_by_zero = 1'b0;
`endif
endmodule
